// File: rtl/ahb_slave_bridge.sv
// AHB-Lite slave to simple back-end request/ready bridge.
// Accepts one AHB transfer at a time and forwards it to the back-end.
// Misaligned transfers are rejected with a two-cycle ERROR response.
// Back-end errors also produce a two-cycle ERROR response.
//
// state  | meaning
// IDLE   | no data phase pending, zero-wait OKAY
// ACCESS | back-end request active, waiting for ready
// ERR1   | first ERROR cycle (hreadyout low)
// ERR2   | second ERROR cycle (hreadyout high), may accept next transfer
module ahb_slave_bridge #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [3:0]                hprot,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic                      sel,
  output logic [AHB_ADDR_WIDTH-1:0] addr,
  output logic                      write,
  output logic [AHB_DATA_WIDTH-1:0] wdata,
  output logic [3:0]                strb,
  output logic [3:0]                prot,
  input  logic                      ready,
  input  logic [AHB_DATA_WIDTH-1:0] rdata,
  input  logic                      slave_error,
  input  logic                      other_error
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [2:0]                size_q, size_d;
  logic [3:0]                prot_q, prot_d;

  logic accept;
  logic misaligned;
  logic be_err;

  assign be_err = slave_error | other_error;

  // Alignment check on the address phase currently on the bus.
  always_comb begin
    misaligned = 1'b0;
    if (hsize > 3'd2) begin
      misaligned = 1'b1;
    end else if (hsize == 3'd1) begin
      misaligned = haddr[0];
    end else if (hsize == 3'd2) begin
      misaligned = (haddr[1:0] != 2'b00);
    end
  end

  // Next-state and AHB response; a new address phase is only taken in a
  // cycle where this slave itself is completing (hreadyout high).
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    prot_d    = prot_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    sel       = 1'b0;
    accept    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        sel = 1'b1;
        if (!ready) begin
          hreadyout = 1'b0;
        end else if (be_err) begin
          hreadyout = 1'b0;
          hresp     = 1'b1;
          state_d   = ST_ERR2;
        end else begin
          hrdata  = write_q ? '0 : rdata;
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    accept = hreadyout & hsel & hready & htrans[1];
    if (accept) begin
      addr_d  = haddr;
      write_d = hwrite;
      size_d  = hsize;
      prot_d  = hprot;
      state_d = misaligned ? ST_ERR1 : ST_ACCESS;
    end
  end

  // State and captured address-phase registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      prot_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      prot_q  <= prot_d;
    end
  end

  // Byte strobes for writes in ACCESS; size is already known to be aligned here.
  always_comb begin
    strb = 4'b0000;
    if ((state_q == ST_ACCESS) && write_q) begin
      case (size_q)
        3'd0:    strb = 4'b0001 << addr_q[1:0];
        3'd1:    strb = 4'b0011 << {addr_q[1], 1'b0};
        default: strb = 4'b1111;
      endcase
    end
  end

  assign addr  = addr_q;
  assign write = write_q;
  assign prot  = prot_q;
  assign wdata = hwdata;

endmodule
